// File: rtl/win_tracker_if.sv
// -----------------------------------------------------------------------------
// win_tracker_if
//
// Bundle between the game logic / display side and the win_tracker block.
//
//   win      : per-player win strobes (level or pulse; rising edges count)
//   clear    : synchronous new-match clear
//   wins     : packed counts, player p at [p*WIDTH +: WIDTH]
//   level    : packed levels, player p at [p*LVL_W +: LVL_W]
//   level_up : one-cycle pulse per player when its level increments
//   leader   : lowest index among the players holding the highest count
//   tie      : two or more players share the highest count
//
// Modports:
//   master : game/display side (drives win/clear, reads results)
//   slave  : the tracker itself
// -----------------------------------------------------------------------------
interface win_tracker_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int WIDTH       = 8,
    parameter int LVL_W       = 3
);
    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic [NUM_PLAYERS-1:0]       win;
    logic                         clear;
    logic [NUM_PLAYERS*WIDTH-1:0] wins;
    logic [NUM_PLAYERS*LVL_W-1:0] level;
    logic [NUM_PLAYERS-1:0]       level_up;
    logic [IDX_W-1:0]             leader;
    logic                         tie;

    modport master (
        output win, clear,
        input  wins, level, level_up, leader, tie
    );

    modport slave (
        input  win, clear,
        output wins, level, level_up, leader, tie
    );
endinterface

// File: rtl/win_tracker.sv
// -----------------------------------------------------------------------------
// win_tracker
//
// Counts rising edges of each player's win strobe into saturating per-player
// counters, derives a level every LEVEL_STEP counted wins (saturating at
// MAX_LEVEL) with a one-cycle level_up pulse, and reports the registered
// leader index and tie flag.
//
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : asynchronous, active-low reset
//   bus : win_tracker_if.slave (win, clear in; wins, level, level_up,
//         leader, tie out)
//
// Build option:
//   WIN_SYNC_EN : when defined, each win bit passes a two-flop synchronizer
//                 (reset to 1) before edge detection; win-to-count latency
//                 becomes three sampling edges.
// -----------------------------------------------------------------------------
module win_tracker #(
    parameter int NUM_PLAYERS = 2,
    parameter int WIDTH       = 8,
    parameter int LEVEL_STEP  = 5,
    parameter int MAX_LEVEL   = 7,
    parameter int LVL_W       = 3
) (
    input  logic         clk,
    input  logic         rst,
    win_tracker_if.slave bus
);
    localparam int IDX_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

    localparam logic [WIDTH-1:0]  WINS_MAX  = {WIDTH{1'b1}};
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LEVEL_STEP - 1);
    localparam logic [LVL_W-1:0]  LEVEL_TOP = LVL_W'(MAX_LEVEL);

    logic [NUM_PLAYERS-1:0] win_in;
    logic [NUM_PLAYERS-1:0] win_q;
    logic [NUM_PLAYERS-1:0] ev;

`ifdef WIN_SYNC_EN
    logic [NUM_PLAYERS-1:0] win_s1;
    logic [NUM_PLAYERS-1:0] win_s2;

    // Reset to ones so a strobe already high at reset release looks "old".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_s1 <= '1;
            win_s2 <= '1;
        end else begin
            win_s1 <= bus.win;
            win_s2 <= win_s1;
        end
    end

    assign win_in = win_s2;
`else
    assign win_in = bus.win;
`endif

    // win_q resets to ones so a win held through reset is not counted; it
    // keeps tracking during clear so a held win is not recounted afterwards.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '1;
        end else begin
            win_q <= win_in;
        end
    end

    assign ev = win_in & ~win_q;

    // ------------------------------------------------------------------
    // Per-player counters, step counters and levels
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]       wins_r     [NUM_PLAYERS];
    logic [LVL_W-1:0]       level_r    [NUM_PLAYERS];
    logic [STEP_W-1:0]      step_r     [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] level_up_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these arrays are a handful of flops per player, not a
            // RAM, so they take the async reset like any other register.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                wins_r[p]  <= '0;
                level_r[p] <= '0;
                step_r[p]  <= '0;
            end
            level_up_r <= '0;
        end else begin
            level_up_r <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (bus.clear) begin
                    wins_r[p]  <= '0;
                    level_r[p] <= '0;
                    step_r[p]  <= '0;
                end else if (ev[p] && (wins_r[p] != WINS_MAX)) begin
                    // A saturated counter swallows the event completely,
                    // so step and level freeze along with it.
                    wins_r[p] <= wins_r[p] + WIDTH'(1);
                    if (step_r[p] == STEP_LAST) begin
                        step_r[p] <= '0;
                        if (level_r[p] < LEVEL_TOP) begin
                            level_r[p]    <= level_r[p] + LVL_W'(1);
                            level_up_r[p] <= 1'b1;
                        end
                    end else begin
                        step_r[p] <= step_r[p] + STEP_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Leader / tie, computed from the current counts and registered
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] max_c;
    logic [IDX_W-1:0] lead_c;
    logic             tie_c;
    logic [IDX_W-1:0] leader_r;
    logic             tie_r;

    // NOTE: every variable gets a value before any branch, so this block
    // stays purely combinational with no latch inferred.
    always_comb begin
        max_c  = wins_r[0];
        lead_c = '0;
        tie_c  = 1'b0;
        // Strict '>' keeps the lowest index on equal counts.
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            if (wins_r[p] > max_c) begin
                max_c  = wins_r[p];
                lead_c = IDX_W'(p);
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if ((p != int'(lead_c)) && (wins_r[p] == max_c)) begin
                tie_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leader_r <= '0;
            tie_r    <= (NUM_PLAYERS > 1);
        end else begin
            leader_r <= lead_c;
            tie_r    <= tie_c;
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pack
        assign bus.wins[p*WIDTH +: WIDTH]  = wins_r[p];
        assign bus.level[p*LVL_W +: LVL_W] = level_r[p];
    end

    assign bus.level_up = level_up_r;
    assign bus.leader   = leader_r;
    assign bus.tie      = tie_r;

endmodule

// File: doc/win_tracker.md
Name: win_tracker

Overview:
- Multi-player, parametrised successor to the single-channel win counter.
- Counts rising edges of each player's win strobe into saturating per-player counters and derives a per-player level every LEVEL_STEP wins, with a one-cycle level_up pulse.
- Reports the current leader and a tie flag.
- Sits between game logic (win strobes) and the scoreboard/display and difficulty logic.

Parameters:
- NUM_PLAYERS, 2, number of independent player channels (1..16).
- WIDTH, 8, bits per win counter; saturates at 2^WIDTH-1.
- LEVEL_STEP, 5, wins per level increment (>=1).
- MAX_LEVEL, 7, highest level; level saturates here.
- LVL_W, 3, bits per level field; must hold MAX_LEVEL.
- IDX_W, derived, max(1, clog2(NUM_PLAYERS)); leader index width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- win  in  NUM_PLAYERS  per-player win strobe, level or pulse; only rising edges count.
- clear  in  1  synchronous new-match clear.
- wins  out  NUM_PLAYERS*WIDTH  packed counts; player p at [p*WIDTH +: WIDTH].
- level  out  NUM_PLAYERS*LVL_W  packed levels; player p at [p*LVL_W +: LVL_W].
- level_up  out  NUM_PLAYERS  one-cycle pulse when a player's level increments.
- leader  out  IDX_W  index of the player with the highest count.
- tie  out  1  high when two or more players share the highest count.

Behaviour:
- Reset (rst low, asynchronous):
  - wins, level, level_up, leader and per-player step counters go to 0.
  - tie goes to 1 when NUM_PLAYERS>1, else 0.
  - The edge-detect register win_q goes to all ones, so a win held high through reset release is not counted.
- Edge detect: ev[p] = win[p] & ~win_q[p]. win_q <= win every cycle, including during clear.
- Latency: win[p] first sampled high at edge k (low at edge k-1) -> wins[p] is incremented at edge k. A level held high counts once; it must go low for at least one sampled cycle to count again.
- Counter update per player, with clear having priority:
  - If ev and wins < 2^WIDTH-1: wins += 1.
  - If wins is saturated: the event is ignored entirely; no step or level change.
- Level logic uses a per-player step counter (0..LEVEL_STEP-1) advanced on each counted event:
  - If step == LEVEL_STEP-1: step goes to 0, and if level < MAX_LEVEL then level += 1 and level_up[p]=1 for that cycle.
  - Otherwise step += 1.
  - At MAX_LEVEL the step counter keeps wrapping, but there is no level change and no pulse.
- level_up is registered, high exactly one cycle, deasserted the next cycle unless a new step boundary is hit.
- Simultaneous events: all players update independently in the same cycle. Multiple level_up bits may assert together.
- clear (synchronous, priority over win):
  - wins, level and step counters go to 0; level_up goes to 0.
  - An event in the same cycle is discarded.
  - win_q still updates, so a held win is not recounted after clear.
- Leader/tie:
  - Registered from the current wins registers, so they lag wins by one cycle.
  - leader is the lowest index among the players holding the maximum count.
  - tie=1 if at least two players equal the maximum (all-zero counts included). NUM_PLAYERS=1 gives leader=0, tie=0.
- Reset mid-operation: asynchronous clear of all state. After release, counting resumes only on fresh rising edges.

Optional Feature:
- Macro WIN_SYNC_EN.
- Defined: each win bit passes through a two-flop synchronizer before edge detect. Synchronizer flops reset to 1. Win-to-count latency becomes 3 edges: the count increments at the third edge at which win is sampled high. Use this for win sources from another clock domain or from a pushbutton.
- Undefined: win feeds edge detect directly, with the latency given above.

Test Plan:
- Reset with win=2'b11 held, release, hold 10 cycles -> wins=0/0, level=0, tie=1, leader=0. Drop win, then raise win[0] -> wins[0]=1 at that edge; leader=0, tie=0 one cycle later.
- 5 separate pulses on win[1] (LEVEL_STEP=5) -> wins[1]=5, level[1]=1, level_up[1] high exactly one cycle on the 5th count. 35 pulses total -> level[1]=7; pulse 40 -> level stays 7, no level_up.
- WIDTH=8, 260 pulses on win[0] -> wins[0]=255 after pulse 255; later pulses give no change, no level_up.
- win[0] and win[1] rising in the same cycle, 5th win for both -> both counts +1; level_up=2'b11 for one cycle; tie=1, leader=0 the next cycle.
- clear asserted in the same cycle as a win[0] rising edge, win[0] held high afterwards -> all counts, levels and steps 0; no count after clear deasserts until win[0] toggles low then high.
- With WIN_SYNC_EN defined: a single-cycle-wide win[0] pulse -> wins[0]=1 at the 3rd edge after it is sampled; a held pulse counts once.
